// File: rtl/motor_cmd_sequencer.sv
// Motor duty sequencer: ramps duty_out toward the commanded target on a
// prescaled tick, latches hall faults and snapshots the speed counters.
module motor_cmd_sequencer #(
    parameter int DUTY_WIDTH   = 10,
    parameter int RAMP_DIV     = 1000,
    parameter int RAMP_STEP    = 8,
    parameter int FAULT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  cmd_valid,
    input  logic [DUTY_WIDTH-1:0] cmd_duty,
    output logic                  cmd_ready,
    input  logic                  fault_clear,
    input  logic [2:0]            hall,
    input  logic [7:0]            hall_count,
    input  logic [15:0]           enc_count,
    output logic [DUTY_WIDTH-1:0] duty_out,
    output logic                  fault,
    output logic                  snap_valid,
    output logic [7:0]            snap_hall,
    output logic [15:0]           snap_enc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [15:0]           presc;
    logic [15:0]           inv_cnt;
    logic [DUTY_WIDTH-1:0] target;
    logic [DUTY_WIDTH-1:0] duty_nxt;
    logic                  out_en;
    logic                  tick;
    logic                  hall_bad;
    logic                  trip;
    logic [DUTY_WIDTH:0]   step_w;
    logic [DUTY_WIDTH:0]   tgt_w;
    logic [DUTY_WIDTH:0]   duty_w;

    assign tick     = (presc == 16'(RAMP_DIV - 1));
    assign hall_bad = (hall == 3'b000) || (hall == 3'b111);
    assign trip     = hall_bad && (inv_cnt >= 16'(FAULT_CYCLES - 1));
    // out_en keeps cmd_ready low until the first edge after reset release
    assign cmd_ready = out_en && (state != FAULT);

    assign step_w = (DUTY_WIDTH + 1)'(RAMP_STEP);
    assign tgt_w  = {1'b0, target};
    assign duty_w = {1'b0, duty_out};

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (trip)        state_nxt = FAULT;
                else if (enable) state_nxt = RUN;
            end
            RUN: begin
                if (trip)         state_nxt = FAULT;
                else if (!enable) state_nxt = IDLE;
            end
            FAULT: begin
                if (fault_clear && !hall_bad) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Each branch is guarded so the step never crosses the target or wraps
    always_comb begin
        duty_nxt = duty_out;
        if (tgt_w > duty_w) begin
            if (tgt_w - duty_w <= step_w) duty_nxt = target;
            else duty_nxt = DUTY_WIDTH'(duty_w + step_w);
        end else if (tgt_w < duty_w) begin
            if (duty_w - tgt_w <= step_w) duty_nxt = target;
            else duty_nxt = DUTY_WIDTH'(duty_w - step_w);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            presc      <= '0;
            inv_cnt    <= '0;
            target     <= '0;
            duty_out   <= '0;
            fault      <= 1'b0;
            out_en     <= 1'b0;
            snap_valid <= 1'b0;
            snap_hall  <= '0;
            snap_enc   <= '0;
        end else begin
            state  <= state_nxt;
            out_en <= 1'b1;
            fault  <= (state_nxt == FAULT);
            presc  <= tick ? '0 : presc + 16'd1;

            if (!hall_bad)
                inv_cnt <= '0;
            else if (inv_cnt < 16'(FAULT_CYCLES))
                inv_cnt <= inv_cnt + 16'd1;

            if (state_nxt == FAULT || state == FAULT ||
                (state == RUN && state_nxt == IDLE))
                target <= '0;
            else if (cmd_valid && cmd_ready)
                target <= cmd_duty;

            if (state_nxt != RUN)
                duty_out <= '0;
            else if (state == RUN && tick)
                duty_out <= duty_nxt;

            snap_valid <= tick;
            if (tick) begin
                snap_hall <= hall_count;
                snap_enc  <= enc_count;
            end
        end
    end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Directed bench for motor_cmd_sequencer: ramp vectors per tick,
// then coincident accept, hall fault/clear and async reset sequences.
module tb_motor_cmd_sequencer;

    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          cmd_valid;
    logic [DW-1:0] cmd_duty;
    logic          cmd_ready;
    logic          fault_clear;
    logic [2:0]    hall;
    logic [7:0]    hall_count;
    logic [15:0]   enc_count;
    logic [DW-1:0] duty_out;
    logic          fault;
    logic          snap_valid;
    logic [7:0]    snap_hall;
    logic [15:0]   snap_enc;

    int checks = 0;
    int errors = 0;

    motor_cmd_sequencer #(
        .DUTY_WIDTH  (DW),
        .RAMP_DIV    (4),
        .RAMP_STEP   (8),
        .FAULT_CYCLES(64)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .cmd_valid  (cmd_valid),
        .cmd_duty   (cmd_duty),
        .cmd_ready  (cmd_ready),
        .fault_clear(fault_clear),
        .hall       (hall),
        .hall_count (hall_count),
        .enc_count  (enc_count),
        .duty_out   (duty_out),
        .fault      (fault),
        .snap_valid (snap_valid),
        .snap_hall  (snap_hall),
        .snap_enc   (snap_enc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          cv;
        logic [DW-1:0] cd;
        logic [15:0]   enc;
        logic [7:0]    hc;
        logic [DW-1:0] exp_duty;
    } vec_t;

    vec_t vt[16];

    function automatic vec_t mk(logic en, logic cv, int cd, int enc,
                                int hc, int ed);
        vec_t v;
        v.en       = en;
        v.cv       = cv;
        v.cd       = DW'(cd);
        v.enc      = 16'(enc);
        v.hc       = 8'(hc);
        v.exp_duty = DW'(ed);
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = mk(1, 1,   20, 16'hFFFF, 8'h11,  8);
        vt[1]  = mk(1, 0,    0, 16'h0002, 8'h12, 16);
        vt[2]  = mk(1, 0,    0, 16'h0003, 8'h13, 20);
        vt[3]  = mk(1, 0,    0, 16'h0004, 8'h14, 20);
        vt[4]  = mk(1, 1,    3, 16'h0005, 8'h15, 12);
        vt[5]  = mk(1, 0,    0, 16'h0006, 8'h16,  4);
        vt[6]  = mk(1, 0,    0, 16'h0007, 8'h17,  3);
        vt[7]  = mk(1, 0,    0, 16'h0008, 8'h18,  3);
        vt[8]  = mk(1, 1, 1023, 16'h0009, 8'h19, 11);
        vt[9]  = mk(1, 1,    0, 16'h000A, 8'h1A,  3);
        vt[10] = mk(1, 0,    0, 16'h000B, 8'h1B,  0);
        vt[11] = mk(1, 0,    0, 16'h000C, 8'h1C,  0);
        vt[12] = mk(1, 1,   50, 16'h000D, 8'h1D,  8);
        vt[13] = mk(0, 0,    0, 16'h000E, 8'h1E,  0);
        vt[14] = mk(0, 1,   40, 16'h000F, 8'h1F,  0);
        vt[15] = mk(1, 0,    0, 16'h0010, 8'h20,  8);

        reset_n     = 1'b0;
        enable      = 1'b1;
        cmd_valid   = 1'b0;
        cmd_duty    = '0;
        fault_clear = 1'b0;
        hall        = 3'b001;
        hall_count  = 8'h00;
        enc_count   = 16'h0000;

        step();
        step();
        check("rst_duty", int'(duty_out), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_ready", int'(cmd_ready), 0);
        check("rst_snap_valid", int'(snap_valid), 0);
        check("rst_snap_enc", int'(snap_enc), 0);
        check("rst_snap_hall", int'(snap_hall), 0);

        reset_n = 1'b1;
        step();
        check("ready_after_release", int'(cmd_ready), 1);
        step();
        step();
        check("no_early_tick", int'(snap_valid), 0);
        step();
        check("first_tick", int'(snap_valid), 1);

        for (int i = 0; i < 16; i++) begin
            enable     = vt[i].en;
            cmd_valid  = vt[i].cv;
            cmd_duty   = vt[i].cd;
            enc_count  = vt[i].enc;
            hall_count = vt[i].hc;
            step();
            cmd_valid = 1'b0;
            check($sformatf("v%0d_snap_pulse_end", i), int'(snap_valid), 0);
            step();
            step();
            step();
            check($sformatf("v%0d_duty", i), int'(duty_out),
                  int'(vt[i].exp_duty));
            check($sformatf("v%0d_snap_valid", i), int'(snap_valid), 1);
            check($sformatf("v%0d_snap_enc", i), int'(snap_enc),
                  int'(vt[i].enc));
            check($sformatf("v%0d_snap_hall", i), int'(snap_hall),
                  int'(vt[i].hc));
        end

        // accept landing on the tick edge: old target 40 still ramps
        step();
        step();
        step();
        cmd_valid = 1'b1;
        cmd_duty  = 10'd9;
        step();
        cmd_valid = 1'b0;
        check("coincide_old_target", int'(duty_out), 16);
        repeat (4) step();
        check("coincide_new_target", int'(duty_out), 9);

        hall = 3'b111;
        repeat (63) step();
        hall = 3'b101;
        check("hall63_no_fault", int'(fault), 0);
        check("hall63_ready", int'(cmd_ready), 1);
        step();
        check("hall63_after_valid", int'(fault), 0);

        hall = 3'b000;
        repeat (63) step();
        check("hall000_63_no_fault", int'(fault), 0);
        step();
        check("trip_fault", int'(fault), 1);
        check("trip_duty", int'(duty_out), 0);
        check("trip_ready", int'(cmd_ready), 0);

        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        check("clear_bad_hall_fault", int'(fault), 1);
        check("clear_bad_hall_ready", int'(cmd_ready), 0);
        step();
        hall        = 3'b010;
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        check("clear_ok_fault", int'(fault), 0);
        check("clear_ok_ready", int'(cmd_ready), 1);
        check("clear_ok_duty", int'(duty_out), 0);

        step();
        cmd_valid = 1'b1;
        cmd_duty  = 10'd100;
        step();
        cmd_valid = 1'b0;
        begin
            int n = 0;
            while (duty_out == '0 && n < 20) begin
                step();
                n++;
            end
            check("ramp_started_in_budget", int'(n < 20), 1);
        end
        check("ramp_first_step", int'(duty_out), 8);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_duty", int'(duty_out), 0);
        check("async_rst_ready", int'(cmd_ready), 0);
        check("async_rst_snap_valid", int'(snap_valid), 0);
        step();
        reset_n = 1'b1;
        step();
        step();
        step();
        check("rel_no_early_tick", int'(snap_valid), 0);
        step();
        check("rel_first_tick", int'(snap_valid), 1);
        check("rel_duty", int'(duty_out), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
